// File: rtl/wb_mem_arbiter.sv
// rtl/wb_mem_arbiter.sv - two-master to one-slave Wishbone classic arbiter with cycle-long grants and watchdog
// Grants are held for the whole cyc; ties resolve round-robin or data-first; unacked strobes are aborted.
module wb_mem_arbiter #(
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic [31:0] iwbs_addr_i,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  output logic [31:0] iwbs_dat_o,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,

  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] dwbs_dat_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  input  logic        dwbs_we_i,
  output logic [31:0] dwbs_dat_o,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o,

  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  localparam int WDW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDW-1:0] WDOG_MAX = WDW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ABORT} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           last_d;
  logic [WDW-1:0] wdog;

  logic req_i;
  logic req_d;
  logic tie_to_d;
  logic granted;
  logic stb_raw;
  logic timeout;

  assign req_i    = iwbs_cyc_i & iwbs_stb_i;
  assign req_d    = dwbs_cyc_i & dwbs_stb_i;
  assign tie_to_d = (FIXED_PRIORITY != 0) || !last_d;
  assign granted  = (state == GNT_I) || (state == GNT_D);
  assign stb_raw  = ((state == GNT_I) & iwbs_stb_i) | ((state == GNT_D) & dwbs_stb_i);
  assign timeout  = (TIMEOUT_CYCLES != 0) && granted && (wdog == WDOG_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == GNT_D && state != GNT_D) begin
        last_d <= 1'b1;
      end else if (state_nxt == GNT_I && state != GNT_I) begin
        last_d <= 1'b0;
      end
    end
  end

  // Any state change (grant, handover, abort, release) restarts the wait count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog <= '0;
    end else if (state_nxt != state || wbm_ack_i || wbm_err_i) begin
      wdog <= '0;
    end else if (TIMEOUT_CYCLES != 0 && granted && stb_raw && wdog != WDOG_MAX) begin
      wdog <= wdog + WDW'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    wbm_addr_o = 32'h0;
    wbm_dat_o  = 32'h0;
    wbm_sel_o  = 4'h0;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    iwbs_dat_o = wbm_dat_i;
    dwbs_dat_o = wbm_dat_i;
    iwbs_ack_o = 1'b0;
    iwbs_err_o = 1'b0;
    dwbs_ack_o = 1'b0;
    dwbs_err_o = 1'b0;

    case (state)
      IDLE: begin
        if (req_d && (!req_i || tie_to_d)) begin
          state_nxt = GNT_D;
        end else if (req_i) begin
          state_nxt = GNT_I;
        end
      end
      GNT_I: begin
        wbm_addr_o = iwbs_addr_i;
        wbm_sel_o  = 4'hF;
        wbm_cyc_o  = iwbs_cyc_i & ~timeout;
        wbm_stb_o  = iwbs_stb_i & ~timeout;
        iwbs_ack_o = iwbs_stb_i & wbm_ack_i & ~timeout;
        iwbs_err_o = (iwbs_stb_i & wbm_err_i) | timeout;
        if (timeout) begin
          state_nxt = ABORT;
        end else if (!iwbs_cyc_i) begin
          state_nxt = req_d ? GNT_D : IDLE;
        end
      end
      GNT_D: begin
        wbm_addr_o = dwbs_addr_i;
        wbm_dat_o  = dwbs_dat_i;
        wbm_sel_o  = dwbs_sel_i;
        wbm_we_o   = dwbs_we_i;
        wbm_cyc_o  = dwbs_cyc_i & ~timeout;
        wbm_stb_o  = dwbs_stb_i & ~timeout;
        dwbs_ack_o = dwbs_stb_i & wbm_ack_i & ~timeout;
        dwbs_err_o = (dwbs_stb_i & wbm_err_i) | timeout;
        if (timeout) begin
          state_nxt = ABORT;
        end else if (!dwbs_cyc_i) begin
          state_nxt = req_i ? GNT_I : IDLE;
        end
      end
      ABORT: begin
        // last_d still names the aborted master; wait for it to close its cycle.
        if (last_d ? !dwbs_cyc_i : !iwbs_cyc_i) begin
          if (last_d ? req_i : req_d) begin
            state_nxt = last_d ? GNT_I : GNT_D;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb/tb_wb_mem_arbiter.sv - scoreboard bench for wb_mem_arbiter (round-robin and fixed-priority instances)
// A shared slave model serves whichever instance is selected; masters are driven by tasks.
module tb_wb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] i_addr, d_addr, d_wdat;
  logic [3:0]  d_sel;
  logic        i_cyc, i_stb, d_cyc, d_stb, d_we;

  logic        s_ack = 1'b0;
  int          s_cnt = 0;
  logic        late_ack, slave_en;
  logic        ack_in;
  logic [31:0] s_dat;

  logic [31:0] o_i_dat [2];
  logic [31:0] o_d_dat [2];
  logic [31:0] o_addr  [2];
  logic [31:0] o_wdat  [2];
  logic [3:0]  o_sel   [2];
  logic        o_i_ack [2];
  logic        o_i_err [2];
  logic        o_d_ack [2];
  logic        o_d_err [2];
  logic        o_cyc   [2];
  logic        o_stb   [2];
  logic        o_we    [2];

  logic use_fp;
  logic [31:0] m_i_dat, m_d_dat, m_addr, m_wdat;
  logic [3:0]  m_sel;
  logic        m_i_ack, m_i_err, m_d_ack, m_d_err, m_cyc, m_stb, m_we;

  int cyc_n = 0;
  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] i_exp[$];
  logic [31:0] d_exp[$];
  int exp_order[$];
  int got_order[$];
  int i_t_req, i_t_own, i_t_drop, d_t_req, d_t_own, d_t_drop;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_mem_arbiter #(.FIXED_PRIORITY(g), .TIMEOUT_CYCLES(4)) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .iwbs_addr_i(i_addr), .iwbs_cyc_i(i_cyc), .iwbs_stb_i(i_stb),
      .iwbs_dat_o(o_i_dat[g]), .iwbs_ack_o(o_i_ack[g]), .iwbs_err_o(o_i_err[g]),
      .dwbs_addr_i(d_addr), .dwbs_dat_i(d_wdat), .dwbs_sel_i(d_sel),
      .dwbs_cyc_i(d_cyc), .dwbs_stb_i(d_stb), .dwbs_we_i(d_we),
      .dwbs_dat_o(o_d_dat[g]), .dwbs_ack_o(o_d_ack[g]), .dwbs_err_o(o_d_err[g]),
      .wbm_addr_o(o_addr[g]), .wbm_dat_o(o_wdat[g]), .wbm_sel_o(o_sel[g]),
      .wbm_cyc_o(o_cyc[g]), .wbm_stb_o(o_stb[g]), .wbm_we_o(o_we[g]),
      .wbm_dat_i(s_dat), .wbm_ack_i(ack_in), .wbm_err_i(1'b0)
    );
  end

  assign m_i_dat = o_i_dat[use_fp];
  assign m_d_dat = o_d_dat[use_fp];
  assign m_addr  = o_addr[use_fp];
  assign m_wdat  = o_wdat[use_fp];
  assign m_sel   = o_sel[use_fp];
  assign m_i_ack = o_i_ack[use_fp];
  assign m_i_err = o_i_err[use_fp];
  assign m_d_ack = o_d_ack[use_fp];
  assign m_d_err = o_d_err[use_fp];
  assign m_cyc   = o_cyc[use_fp];
  assign m_stb   = o_stb[use_fp];
  assign m_we    = o_we[use_fp];

  function automatic logic [31:0] resp(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign ack_in = s_ack | late_ack;
  assign s_dat  = ack_in ? resp(m_addr) : 32'h0;

  // Slave acks in the third cycle of a strobe, then drops for one cycle.
  always @(posedge clk) begin
    cyc_n <= cyc_n + 1;
    if (!m_stb || s_ack) begin
      s_cnt <= 0;
      s_ack <= 1'b0;
    end else if (s_cnt == 1) begin
      s_ack <= slave_en;
    end else begin
      s_cnt <= s_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_order();
    chk("order_len", got_order.size(), exp_order.size());
    for (int k = 0; k < got_order.size() && k < exp_order.size(); k++) begin
      chk("order", got_order[k], exp_order[k]);
    end
    got_order.delete();
    exp_order.delete();
  endtask

  task automatic i_txn(input logic [31:0] addr);
    bit done;
    bit owned;
    done = 0;
    owned = 0;
    @(posedge clk); #1;
    i_t_req = cyc_n;
    i_addr = addr; i_cyc = 1'b1; i_stb = 1'b1;
    i_exp.push_back(resp(addr));
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (m_stb && m_addr[31] && !owned) begin
        owned = 1;
        i_t_own = cyc_n;
        chk("i_sel", m_sel, 4'hF);
        chk("i_we", m_we, 0);
      end
      if (m_i_err) chk("i_err", 1, 0);
      if (m_i_ack) begin
        done = 1;
        chk("i_dat", m_i_dat, i_exp.pop_front());
        chk("i_ack_src", ack_in, 1);
        chk("d_no_ack", m_d_ack, 0);
        got_order.push_back(0);
      end
    end
    if (!done) begin
      chk("i_wait", 0, 1);
      i_exp.delete();
    end
    @(posedge clk); #1;
    i_stb = 1'b0; i_cyc = 1'b0;
    i_t_drop = cyc_n;
  endtask

  task automatic d_txn(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                       input logic [31:0] wdat, input int beats);
    bit done;
    bit owned;
    owned = 0;
    @(posedge clk); #1;
    d_t_req = cyc_n;
    d_cyc = 1'b1; d_we = we; d_sel = sel; d_wdat = wdat;
    for (int b = 0; b < beats; b++) begin
      done = 0;
      d_addr = addr + 32'(b * 4);
      d_stb = 1'b1;
      d_exp.push_back(resp(d_addr));
      for (int k = 0; k < 60 && !done; k++) begin
        @(negedge clk);
        if (m_stb && !m_addr[31] && !owned) begin
          owned = 1;
          d_t_own = cyc_n;
          chk("d_sel", m_sel, sel);
          chk("d_we", m_we, we);
          chk("d_wdat", m_wdat, wdat);
        end
        if (m_d_err) chk("d_err", 1, 0);
        if (m_d_ack) begin
          done = 1;
          chk("d_dat", m_d_dat, d_exp.pop_front());
          chk("d_bus_own", m_addr[31], 0);
          chk("i_no_ack", m_i_ack, 0);
          got_order.push_back(1);
        end
      end
      if (!done) begin
        chk("d_wait", 0, 1);
        d_exp.delete();
      end
      @(posedge clk); #1;
      d_stb = 1'b0;
      if (b != beats - 1) begin
        @(posedge clk); #1;
      end
    end
    d_cyc = 1'b0;
    d_t_drop = cyc_n;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic tie();
    fork
      i_txn(32'h8000_0040);
      d_txn(32'h1000_0080, 1'b0, 4'hF, 32'h0, 1);
    join
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0, t_err;
    bit got_err;
    rst_n = 1'b0; use_fp = 1'b0; slave_en = 1'b1; late_ack = 1'b0;
    i_addr = 0; i_cyc = 0; i_stb = 0;
    d_addr = 0; d_wdat = 0; d_sel = 0; d_cyc = 0; d_stb = 0; d_we = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {m_cyc, m_stb, m_we, m_sel, m_i_ack, m_i_err, m_d_ack, m_d_err}, 0);
    chk("rst_addr", m_addr, 0);
    chk("rst_wdat", m_wdat, 0);
    chk("rst_rdat", m_i_dat | m_d_dat, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    i_txn(32'h8000_0000);
    exp_order.push_back(0);
    chk("i_lat", i_t_own - i_t_req, 1);
    check_order();

    fork
      i_txn(32'h8000_0010);
      d_txn(32'h1000_0020, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1);
    join
    exp_order = '{1, 0};
    chk("d_lat", d_t_own - d_t_req, 1);
    chk("handover_d_i", i_t_own - d_t_drop, 1);
    check_order();

    tie();
    exp_order = '{1, 0};
    check_order();

    d_txn(32'h1000_0100, 1'b1, 4'b1100, 32'h1234_5678, 1);
    tie();
    exp_order = '{1, 0, 1};
    chk("handover_i_d", d_t_own - i_t_drop, 1);
    check_order();

    fork
      d_txn(32'h1000_0200, 1'b0, 4'hF, 32'h0, 4);
      begin
        @(posedge clk);
        i_txn(32'h8000_0200);
      end
    join
    exp_order = '{1, 1, 1, 1, 0};
    chk("burst_handover", i_t_own - d_t_drop, 1);
    check_order();

    use_fp = 1'b1;
    reset_pulse();
    for (int r = 0; r < 3; r++) begin
      d_txn(32'h1000_0300, 1'b0, 4'hF, 32'h0, 1);
      tie();
      exp_order = '{1, 1, 0};
      chk("fp_handover", i_t_own - d_t_drop, 1);
      check_order();
    end

    use_fp = 1'b0;
    reset_pulse();
    slave_en = 1'b0;
    @(posedge clk); #1;
    t0 = cyc_n;
    d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0; d_sel = 4'hF; d_addr = 32'h1000_0400;
    got_err = 0;
    t_err = 0;
    for (int k = 0; k < 20 && !got_err; k++) begin
      @(negedge clk);
      if (m_d_err) begin
        got_err = 1;
        t_err = cyc_n;
      end
    end
    chk("to_seen", got_err, 1);
    chk("to_lat", t_err - t0, 5);
    chk("to_cyc", m_cyc, 0);
    chk("to_stb", m_stb, 0);
    @(negedge clk);
    chk("to_pulse", m_d_err, 0);
    chk("abort_cyc", m_cyc, 0);
    @(posedge clk); #1 late_ack = 1'b1;
    @(negedge clk);
    chk("late_ack", m_d_ack, 0);
    chk("late_err", m_d_err, 0);
    @(posedge clk); #1;
    late_ack = 1'b0; d_stb = 1'b0; d_cyc = 1'b0; slave_en = 1'b1;
    d_txn(32'h1000_0500, 1'b0, 4'hF, 32'h0, 1);
    exp_order.push_back(1);
    chk("post_abort_lat", d_t_own - d_t_req, 1);
    check_order();

    slave_en = 1'b0;
    @(posedge clk); #1;
    d_cyc = 1'b1; d_stb = 1'b1; d_addr = 32'h1000_0600;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_stb", m_stb, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl", {m_cyc, m_stb, m_we, m_sel, m_i_ack, m_i_err, m_d_ack, m_d_err}, 0);
    chk("mid_rst_addr", m_addr, 0);
    chk("mid_rst_wdat", m_wdat, 0);
    chk("mid_rst_rdat", m_i_dat | m_d_dat, 0);
    d_cyc = 1'b0; d_stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; slave_en = 1'b1;
    tie();
    exp_order = '{1, 0};
    check_order();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
